// File: rtl/cap_scan_scheduler.sv
`timescale 1ns/1ps
// cap_scan_scheduler
//   Shares a single charge / release / count measurement engine across
//   N_PADS capacitive touch pads. Each pad is driven high, released, and
//   its discharge time counted. The count is compared with a per-pad
//   self-calibrating baseline to produce a hysteretic touch flag.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        scan enable, sampled only in IDLE and NEXT
//   pad_in        raw asynchronous pad levels (N_PADS)
//   pad_out       pad drive value; only bit cur_pad can be set
//   pad_oe        pad output enable (1 = drive); only bit cur_pad can be set
//   touched       registered per-pad touch state
//   cur_pad       index of the pad being measured
//   scan_done     one-cycle pulse when the sweep wraps back to pad 0
//   timeout_seen  sticky per-pad flag: discharge count reached TIMEOUT

module cap_scan_scheduler #(
  parameter int unsigned N_PADS        = 4,
  parameter int unsigned CHARGE_CYCLES = 16,
  parameter int unsigned CNT_W         = 10,
  parameter int unsigned TIMEOUT       = 1023,
  parameter int unsigned THRESH        = 8,
  parameter int unsigned BASE_SHIFT    = 3,
  localparam int unsigned PAD_W        = (N_PADS > 1) ? $clog2(N_PADS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [N_PADS-1:0] pad_in,
  output logic [N_PADS-1:0] pad_out,
  output logic [N_PADS-1:0] pad_oe,
  output logic [N_PADS-1:0] touched,
  output logic [PAD_W-1:0]  cur_pad,
  output logic              scan_done,
  output logic [N_PADS-1:0] timeout_seen
);

  localparam int unsigned TMR_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
  localparam int unsigned EXT_W = CNT_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    CHARGE,
    RELEASE,
    EVAL,
    NEXT
  } state_t;

  state_t state_q, state_d;

  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PAD_W-1:0]  cur_pad_d;
  logic [N_PADS-1:0] touched_d;
  logic [N_PADS-1:0] timeout_d;
  logic              scan_done_d;
  logic [N_PADS-1:0] pad_oe_d;

  logic [N_PADS-1:0] sync1, sync2;
  logic              pad_sync;

  logic [CNT_W-1:0]  baseline [N_PADS];
  logic [N_PADS-1:0] base_valid;
  logic [CNT_W-1:0]  base_cur;
  logic              base_we;
  logic [CNT_W-1:0]  base_new;
  logic              touch_new;

  // Evaluation arithmetic, one bit wider than the counter so that
  // baseline + THRESH cannot wrap.
  logic [EXT_W-1:0]        cnt_ext, base_ext, thr_hi, thr_lo;
  logic signed [EXT_W-1:0] diff, step, base_iir;

  assign base_cur = baseline[cur_pad];
  assign pad_sync = sync2[cur_pad];

  assign cnt_ext  = EXT_W'(count_q);
  assign base_ext = EXT_W'(base_cur);
  assign thr_hi   = base_ext + EXT_W'(THRESH);
  assign thr_lo   = base_ext + EXT_W'(THRESH >> 1);

  // IIR step: floor((count - baseline) / 2^BASE_SHIFT). The result always
  // lies between baseline and count, so it fits CNT_W bits unsigned.
  assign diff     = $signed(cnt_ext) - $signed(base_ext);
  assign step     = diff >>> BASE_SHIFT;
  assign base_iir = $signed(base_ext) + step;

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    count_d     = count_q;
    cur_pad_d   = cur_pad;
    touched_d   = touched;
    timeout_d   = timeout_seen;
    scan_done_d = 1'b0;
    base_we     = 1'b0;
    base_new    = base_cur;
    touch_new   = 1'b0;
    pad_oe_d    = '0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = CHARGE;
          timer_d = '0;
        end
      end

      CHARGE: begin
        if (timer_q == TMR_W'(CHARGE_CYCLES - 1)) begin
          state_d = RELEASE;
          count_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      // Count while the synchronised pad is still high; a stuck-high pad
      // is cut off at TIMEOUT so the sweep never stalls.
      RELEASE: begin
        if (!pad_sync) begin
          state_d = EVAL;
        end else if (count_q == CNT_W'(TIMEOUT)) begin
          state_d            = EVAL;
          timeout_d[cur_pad] = 1'b1;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end

      EVAL: begin
        state_d = NEXT;
        if (!base_valid[cur_pad]) begin
          // First measurement after reset only seeds the baseline.
          base_we  = 1'b1;
          base_new = count_q;
        end else begin
          touch_new = touched[cur_pad];
          if (!touch_new && (cnt_ext > thr_hi)) begin
            touch_new = 1'b1;
          end else if (touch_new && (cnt_ext < thr_lo)) begin
            touch_new = 1'b0;
          end
          touched_d[cur_pad] = touch_new;
          // Baseline tracks drift only while the pad is untouched.
          if (!touch_new) begin
            base_we  = 1'b1;
            base_new = CNT_W'(base_iir);
          end
        end
        if (cur_pad == PAD_W'(N_PADS - 1)) begin
          cur_pad_d   = '0;
          scan_done_d = 1'b1;
        end else begin
          cur_pad_d = cur_pad + PAD_W'(1);
        end
      end

      NEXT: begin
        timer_d = '0;
        state_d = enable ? CHARGE : IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Drive only the selected pad, and only while charging.
    if (state_d == CHARGE) begin
      pad_oe_d = N_PADS'(1) << cur_pad_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      count_q      <= '0;
      cur_pad      <= '0;
      pad_oe       <= '0;
      pad_out      <= '0;
      touched      <= '0;
      scan_done    <= 1'b0;
      timeout_seen <= '0;
      base_valid   <= '0;
      baseline     <= '{default: '0};
      sync1        <= '0;
      sync2        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      count_q      <= count_d;
      cur_pad      <= cur_pad_d;
      pad_oe       <= pad_oe_d;
      pad_out      <= pad_oe_d;
      touched      <= touched_d;
      scan_done    <= scan_done_d;
      timeout_seen <= timeout_d;
      sync1        <= pad_in;
      sync2        <= sync1;
      if (base_we) begin
        baseline[cur_pad]   <= base_new;
        base_valid[cur_pad] <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cap_scan_scheduler.md
Name: cap_scan_scheduler

Overview:
- Time-multiplexes one shared charge/release/count measurement engine across N capacitive touch pads on the bidirectional pins.
- Each pad is sequenced in turn: drive high, release, count discharge cycles.
- Each count is compared against a per-pad self-calibrating baseline to produce debounced touch flags.
- Replaces N free-running per-pad sensors with one scheduler plus a single counter.

Parameters:
- N_PADS, 4, number of pads scanned; pad index width is clog2(N_PADS), minimum 1.
- CHARGE_CYCLES, 16, clk cycles a pad is driven high before release.
- CNT_W, 10, discharge counter width.
- TIMEOUT, 1023, discharge count limit; must be ≤ 2^CNT_W-1.
- THRESH, 8, count margin above baseline that declares a touch.
- BASE_SHIFT, 3, baseline IIR shift: baseline += (count-baseline)>>>BASE_SHIFT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  scan enable; sampled only in IDLE and NEXT.
- pad_in  in  N_PADS  raw pad levels from uio_in, asynchronous.
- pad_out  out  N_PADS  pad drive value.
- pad_oe  out  N_PADS  pad output enable, 1=drive.
- touched  out  N_PADS  registered per-pad touch state.
- cur_pad  out  clog2(N_PADS)  index of the pad being measured.
- scan_done  out  1  one-cycle pulse after the last pad is evaluated.
- timeout_seen  out  N_PADS  sticky flag set when a pad's count hit TIMEOUT.

Behaviour:
- Reset (synchronous, same edge):
  - State=IDLE; cur_pad=0.
  - pad_out=0, pad_oe=0, touched=0, scan_done=0, timeout_seen=0.
  - All baselines=0 and all baseline_valid bits=0.
  - Reset in any state aborts the measurement immediately; pads are undriven on the next cycle.
- pad_in passes through a 2-flop synchronizer per bit (2-cycle latency, included in counts). Only bit cur_pad is observed.
- pad_oe/pad_out: only bit cur_pad may be nonzero; all other bits are 0 in every state.
- FSM:
  - IDLE: if enable, go to CHARGE with timer=0.
  - CHARGE: pad_oe[cur_pad]=1, pad_out[cur_pad]=1. Stay exactly CHARGE_CYCLES cycles, then go to RELEASE with count=0.
  - RELEASE: pad_oe=0. count increments each cycle while synced pad_in[cur_pad]==1. Exit to EVAL on the first cycle synced input is 0, or when count==TIMEOUT. Timeout sets timeout_seen[cur_pad]; count holds TIMEOUT.
  - EVAL (1 cycle):
    - If !baseline_valid: baseline=count, valid=1, touched unchanged (0).
    - Else if touched==0 and count > baseline+THRESH: touched=1.
    - Else if touched==1 and count < baseline+(THRESH>>1): touched=0 (hysteresis).
    - Baseline updates only when touched is 0 after this evaluation.
    - Comparisons use CNT_W+1 bits to prevent overflow.
    - IIR uses a signed CNT_W+1 difference with arithmetic shift. Baseline never underflows or overflows.
  - NEXT (1 cycle):
    - cur_pad increments, wrapping to 0 after N_PADS-1.
    - On wrap, scan_done=1 for this one cycle.
    - If enable, go to CHARGE; else go to IDLE.
- Deasserting enable mid-measurement lets the current pad finish. touched and baselines are retained in IDLE.
- Per-pad period = CHARGE_CYCLES + count + 1 (release exit) + 1 (EVAL) + 1 (NEXT) cycles.
- timeout_seen is cleared only by reset.

Test Plan:
- Reset then enable=1 with model pads discharging after 40 cycles:
  - pad_oe[0] high for exactly 16 cycles.
  - cur_pad sequences 0,1,2,3,0.
  - scan_done pulses once per sweep.
  - touched stays 0; baselines are ≈ 40+sync latency.
- After 4 sweeps, pad 2 discharge lengthens by 20 cycles:
  - touched[2]=1 at EVAL of its next measurement.
  - Other bits stay 0; baseline[2] is frozen.
- Return pad 2 to its nominal value:
  - touched[2] clears at the next EVAL.
  - A value of baseline+5 (between THRESH/2 and THRESH) holds touched unchanged.
- Pad 1 held at 1 (stuck):
  - Count reaches 1023.
  - timeout_seen[1]=1 (sticky).
  - Scan continues to pad 2 without stalling.
- reset asserted mid-RELEASE of pad 3:
  - Next cycle: all outputs 0, cur_pad=0, baselines invalid.
  - The first sweep after reset produces no touch.
- enable dropped during CHARGE of pad 1:
  - Pad 1 completes EVAL.
  - FSM enters IDLE with cur_pad=2 and no further pad_oe activity.
